// File: rtl/epl_correlator_if.sv
// Sample/code/dump inputs and dumped correlation results of the early/prompt/late correlator.
// The master side is the tracking channel and the slave side is the correlator.
interface epl_correlator_if #(
  parameter int IN_WIDTH  = 3,
  parameter int ACC_WIDTH = 16,
  parameter int CNT_WIDTH = 16
);
  logic                        sample_valid;
  logic signed [IN_WIDTH-1:0]  i_in;
  logic signed [IN_WIDTH-1:0]  q_in;
  logic                        code_early;
  logic                        code_prompt;
  logic                        code_late;
  logic                        dump;

  logic signed [ACC_WIDTH-1:0] i_early;
  logic signed [ACC_WIDTH-1:0] q_early;
  logic signed [ACC_WIDTH-1:0] i_prompt;
  logic signed [ACC_WIDTH-1:0] q_prompt;
  logic signed [ACC_WIDTH-1:0] i_late;
  logic signed [ACC_WIDTH-1:0] q_late;
  logic [CNT_WIDTH-1:0]        sample_count;
  logic                        overflow;
  logic                        acc_valid;

  modport master (
    output sample_valid, i_in, q_in, code_early, code_prompt, code_late, dump,
    input  i_early, q_early, i_prompt, q_prompt, i_late, q_late,
    input  sample_count, overflow, acc_valid
  );

  modport slave (
    input  sample_valid, i_in, q_in, code_early, code_prompt, code_late, dump,
    output i_early, q_early, i_prompt, q_prompt, i_late, q_late,
    output sample_count, overflow, acc_valid
  );
endinterface

// File: rtl/epl_correlator.sv
// Early/prompt/late correlator: wipes each valid I/Q sample off three code replicas
// and integrates the six products with saturation until the channel asserts dump.
module epl_correlator #(
  parameter int IN_WIDTH  = 3,
  parameter int ACC_WIDTH = 16,
  parameter int CNT_WIDTH = 16
) (
  input logic              clk,
  input logic              reset,
  epl_correlator_if.slave  bus
);
  localparam int LANES = 6;
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  logic [2:0]           code_bits;
  logic [LANES-1:0]     clamp;
  logic                 valid_d;
  logic                 dump_d;
  logic                 ovf_int;
  logic                 overflow_q;
  logic                 acc_valid_q;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] cnt_next;
  logic [CNT_WIDTH-1:0] count_q;

  assign code_bits = {bus.code_late, bus.code_prompt, bus.code_early};

  // Lanes in order: I/Q early, I/Q prompt, I/Q late.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic signed [IN_WIDTH-1:0]  sample;
    logic                        code;
    logic signed [IN_WIDTH:0]    prod;
    logic signed [ACC_WIDTH:0]   wide;
    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] sum;
    logic signed [ACC_WIDTH-1:0] dumped;
    logic                        clamp_l;

    assign sample = (l % 2 == 0) ? bus.i_in : bus.q_in;
    assign code   = code_bits[l/2];

    // One guard bit above the accumulator exposes any two's-complement wrap.
    always_comb begin
      wide = {acc[ACC_WIDTH-1], acc};
      if (valid_d) begin
        wide = wide + {{(ACC_WIDTH-IN_WIDTH){prod[IN_WIDTH]}}, prod};
      end
      clamp_l = (wide[ACC_WIDTH] != wide[ACC_WIDTH-1]);
      sum     = wide[ACC_WIDTH-1:0];
      if (clamp_l) begin
        sum = wide[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
      end
    end

    assign clamp[l] = clamp_l;

    always_ff @(posedge clk) begin
      if (reset) begin
        prod   <= '0;
        acc    <= '0;
        dumped <= '0;
      end else begin
        if (!bus.sample_valid) begin
          prod <= '0;
        end else if (code) begin
          prod <= {sample[IN_WIDTH-1], sample};
        end else begin
          prod <= -{sample[IN_WIDTH-1], sample};
        end
        if (dump_d) begin
          dumped <= sum;
          acc    <= '0;
        end else begin
          acc <= sum;
        end
      end
    end
  end

  assign cnt_next = (valid_d && (cnt != '1)) ? cnt + 1'b1 : cnt;

  // A dump in stage 2 still folds in the stage-1 sample before closing the interval.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_d     <= 1'b0;
      dump_d      <= 1'b0;
      cnt         <= '0;
      ovf_int     <= 1'b0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      acc_valid_q <= 1'b0;
    end else begin
      valid_d     <= bus.sample_valid;
      dump_d      <= bus.dump;
      acc_valid_q <= dump_d;
      if (dump_d) begin
        count_q    <= cnt_next;
        overflow_q <= ovf_int | (|clamp);
        cnt        <= '0;
        ovf_int    <= 1'b0;
      end else begin
        cnt     <= cnt_next;
        ovf_int <= ovf_int | (|clamp);
      end
    end
  end

  assign bus.i_early      = g_lane[0].dumped;
  assign bus.q_early      = g_lane[1].dumped;
  assign bus.i_prompt     = g_lane[2].dumped;
  assign bus.q_prompt     = g_lane[3].dumped;
  assign bus.i_late       = g_lane[4].dumped;
  assign bus.q_late       = g_lane[5].dumped;
  assign bus.sample_count = count_q;
  assign bus.overflow     = overflow_q;
  assign bus.acc_valid    = acc_valid_q;
endmodule

// File: tb/tb_epl_correlator.sv
// Bench for epl_correlator: a 16-bit and an 8-bit accumulator instance share one stimulus
// stream and are compared every cycle against an interval-level arithmetic model.
module tb_epl_correlator;
  logic clk = 1'b1;
  logic reset;
  logic sv, ce, cp, cl, dmp;
  logic signed [2:0] iv, qv;

  always #5 clk = ~clk;

  epl_correlator_if #(.IN_WIDTH(3), .ACC_WIDTH(16), .CNT_WIDTH(16)) bus16 ();
  epl_correlator_if #(.IN_WIDTH(3), .ACC_WIDTH(8),  .CNT_WIDTH(16)) bus8 ();

  assign bus16.sample_valid = sv;
  assign bus16.i_in         = iv;
  assign bus16.q_in         = qv;
  assign bus16.code_early   = ce;
  assign bus16.code_prompt  = cp;
  assign bus16.code_late    = cl;
  assign bus16.dump         = dmp;
  assign bus8.sample_valid  = sv;
  assign bus8.i_in          = iv;
  assign bus8.q_in          = qv;
  assign bus8.code_early    = ce;
  assign bus8.code_prompt   = cp;
  assign bus8.code_late     = cl;
  assign bus8.dump          = dmp;

  epl_correlator #(.IN_WIDTH(3), .ACC_WIDTH(16), .CNT_WIDTH(16)) dut16 (
    .clk(clk), .reset(reset), .bus(bus16));
  epl_correlator #(.IN_WIDTH(3), .ACC_WIDTH(8), .CNT_WIDTH(16)) dut8 (
    .clk(clk), .reset(reset), .bus(bus8));

  typedef struct packed {
    int              due;
    logic            strobe;
    logic [5:0][15:0] v16;
    logic [5:0][7:0]  v8;
    logic [15:0]     cnt;
    logic            ovf16;
    logic            ovf8;
  } rec_t;

  typedef struct packed {
    logic [5:0][15:0] v16;
    logic [15:0]      cnt;
    logic             ovf16;
    logic [7:0]       ie8;
    logic             ovf8;
  } cap_t;

  rec_t  exp_q[$];
  cap_t  caps[$];
  int    cyc = 0;
  int    errors = 0;
  int    checks = 0;
  int    m16[6], m8[6], mcnt;
  bit    mo16, mo8;
  int    e16[6], e8[6], ecnt;
  bit    eo16, eo8;
  string lname[6] = '{"i_early", "q_early", "i_prompt", "q_prompt", "i_late", "q_late"};

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic int add_sat(input int a, input int b, input int w, output bit c);
    int hi = (1 << (w - 1)) - 1;
    int lo = -(1 << (w - 1));
    int s  = a + b;
    c = 1'b0;
    if (s > hi) begin s = hi; c = 1'b1; end
    else if (s < lo) begin s = lo; c = 1'b1; end
    return s;
  endfunction

  task automatic clear_model();
    for (int l = 0; l < 6; l++) begin m16[l] = 0; m8[l] = 0; end
    mcnt = 0; mo16 = 0; mo8 = 0;
  endtask

  // Interval-level model: what each dump must report and in which cycle it appears.
  task automatic model_apply();
    rec_t r;
    int   s, p;
    bit   code, c;
    if (reset) begin
      clear_model();
      while (exp_q.size() > 0 && exp_q[$].due > cyc) void'(exp_q.pop_back());
      r = '0;
      r.due = cyc + 1;
      exp_q.push_back(r);
    end else begin
      if (sv) begin
        for (int l = 0; l < 6; l++) begin
          s = (l % 2 == 0) ? int'(iv) : int'(qv);
          code = (l < 2) ? ce : ((l < 4) ? cp : cl);
          p = code ? s : -s;
          m16[l] = add_sat(m16[l], p, 16, c); mo16 |= c;
          m8[l]  = add_sat(m8[l], p, 8, c);   mo8  |= c;
        end
        if (mcnt < 65535) mcnt++;
      end
      if (dmp) begin
        r = '0;
        r.due = cyc + 2;
        r.strobe = 1'b1;
        for (int l = 0; l < 6; l++) begin
          r.v16[l] = 16'(m16[l]);
          r.v8[l]  = 8'(m8[l]);
        end
        r.cnt = 16'(mcnt); r.ovf16 = mo16; r.ovf8 = mo8;
        exp_q.push_back(r);
        clear_model();
      end
    end
  endtask

  task automatic checkOutput();
    rec_t r;
    bit   strobe;
    int   a16[6], a8[6];
    cap_t cp_v;
    strobe = 1'b0;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      r = exp_q.pop_front();
      for (int l = 0; l < 6; l++) begin e16[l] = $signed(r.v16[l]); e8[l] = $signed(r.v8[l]); end
      ecnt = int'(r.cnt); eo16 = r.ovf16; eo8 = r.ovf8; strobe = r.strobe;
    end
    a16 = '{bus16.i_early, bus16.q_early, bus16.i_prompt, bus16.q_prompt, bus16.i_late, bus16.q_late};
    a8  = '{bus8.i_early, bus8.q_early, bus8.i_prompt, bus8.q_prompt, bus8.i_late, bus8.q_late};
    check("acc_valid16", int'(bus16.acc_valid), int'(strobe));
    check("acc_valid8", int'(bus8.acc_valid), int'(strobe));
    for (int l = 0; l < 6; l++) begin
      check({lname[l], "16"}, a16[l], e16[l]);
      check({lname[l], "8"}, a8[l], e8[l]);
    end
    check("sample_count16", int'(bus16.sample_count), ecnt);
    check("sample_count8", int'(bus8.sample_count), ecnt);
    check("overflow16", int'(bus16.overflow), int'(eo16));
    check("overflow8", int'(bus8.overflow), int'(eo8));
    if (bus16.acc_valid) begin
      for (int l = 0; l < 6; l++) cp_v.v16[l] = 16'(a16[l]);
      cp_v.cnt = bus16.sample_count; cp_v.ovf16 = bus16.overflow;
      cp_v.ie8 = bus8.i_early; cp_v.ovf8 = bus8.overflow;
      caps.push_back(cp_v);
    end
  endtask

  task automatic applyStimulus(input bit r, input bit v, input int i, input int q,
                               input bit e, input bit p, input bit l, input bit d);
    reset = r; sv = v; iv = 3'(i); qv = 3'(q); ce = e; cp = p; cl = l; dmp = d;
    model_apply();
    @(negedge clk);
    if (cyc > 0) checkOutput();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  function automatic cap_t get_cap(input int n);
    cap_t z = '0;
    return (n < caps.size()) ? caps[n] : z;
  endfunction

  initial begin
    cap_t c;
    clear_model();
    for (int l = 0; l < 6; l++) begin e16[l] = 0; e8[l] = 0; end
    ecnt = 0; eo16 = 0; eo8 = 0;

    for (int k = 0; k < 3; k++) applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    idle(6);
    check("s1_no_pulse", caps.size(), 0);

    for (int n = 1; n <= 10; n++) applyStimulus(0, 1, 3, -2, 1, 1, 1, n == 10);
    idle(4);
    c = get_cap(0);
    check("s2_pulses", caps.size(), 1);
    check("s2_i_early", $signed(c.v16[0]), 30);
    check("s2_q_late", $signed(c.v16[5]), -20);
    check("s2_count", int'(c.cnt), 10);
    check("s2_ovf", int'(c.ovf16), 0);
    caps.delete();

    for (int n = 1; n <= 10; n++) applyStimulus(0, 1, 3, -2, 0, 1, n % 2, n == 10);
    idle(4);
    c = get_cap(0);
    check("s3_i_early", $signed(c.v16[0]), -30);
    check("s3_q_early", $signed(c.v16[1]), 20);
    check("s3_i_prompt", $signed(c.v16[2]), 30);
    check("s3_i_late", $signed(c.v16[4]), 0);
    check("s3_q_late", $signed(c.v16[5]), 0);
    caps.delete();

    for (int n = 0; n < 5; n++) applyStimulus(0, 1, -4, 0, 1, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 1, 1);
    applyStimulus(0, 1, -4, 0, 1, 0, 1, 1);
    idle(4);
    check("s4_pulses", caps.size(), 2);
    c = get_cap(0);
    check("s4_i_prompt", $signed(c.v16[2]), 20);
    check("s4_count_a", int'(c.cnt), 5);
    c = get_cap(1);
    check("s4_count_b", int'(c.cnt), 1);
    check("s4_i_prompt_b", $signed(c.v16[2]), 4);
    caps.delete();

    for (int n = 1; n <= 50; n++) applyStimulus(0, 1, 3, 0, 1, 1, 1, n == 50);
    for (int n = 1; n <= 2; n++) applyStimulus(0, 1, 3, 0, 1, 1, 1, n == 2);
    idle(4);
    c = get_cap(0);
    check("s5_i_early8", $signed(c.ie8), 127);
    check("s5_ovf8", int'(c.ovf8), 1);
    check("s5_i_early16", $signed(c.v16[0]), 150);
    check("s5_count", int'(c.cnt), 50);
    c = get_cap(1);
    check("s5_i_early8_b", $signed(c.ie8), 6);
    check("s5_ovf8_b", int'(c.ovf8), 0);
    caps.delete();

    for (int n = 0; n < 7; n++) applyStimulus(0, 1, 3, 1, 1, 1, 1, 0);
    applyStimulus(1, 1, 3, 1, 1, 1, 1, 0);
    for (int n = 1; n <= 4; n++) applyStimulus(0, 1, 3, 1, 1, 1, 1, n == 4);
    idle(4);
    c = get_cap(0);
    check("s6_pulses", caps.size(), 1);
    check("s6_i_early", $signed(c.v16[0]), 12);
    check("s6_count", int'(c.cnt), 4);
    caps.delete();

    // Random traffic including dumps near resets and back-to-back dumps.
    for (int n = 0; n < 2000; n++) begin
      applyStimulus($urandom_range(199) == 0, $urandom_range(3) != 0,
                    int'($urandom_range(7)) - 4, int'($urandom_range(7)) - 4,
                    $urandom_range(1) == 1, $urandom_range(1) == 1, $urandom_range(1) == 1,
                    $urandom_range(7) == 0);
    end
    idle(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
